udma_ch_addrgen_2d: RTL and testbench



---
 rtl/udma_addrgen_pkg.sv | 33 +++
 rtl/udma_addrgen_cfg_shadow.sv | 36 +++
 rtl/udma_ch_addrgen_2d.sv | 161 ++++++++++++++++
 tb/tb_udma_ch_addrgen_2d.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udma_addrgen_pkg.sv
// rtl/udma_addrgen_pkg.sv - shared types and helpers for the uDMA channel address generator
package udma_addrgen_pkg;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned TRANS_W  = 20;
  localparam int unsigned STRIDE_W = 19;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } datasize_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   start;
    logic [TRANS_W-1:0]  size;
    logic [STRIDE_W-1:0] row_len;
    logic [STRIDE_W-1:0] stride;
    logic                mode_2d;
  } addrgen_cfg_t;

  // A zero increment marks the reserved encoding, which never forms a beat.
  function automatic logic [2:0] datasize_to_inc(input datasize_e ds);
    case (ds)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      WORD:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/udma_addrgen_cfg_shadow.sv
// rtl/udma_addrgen_cfg_shadow.sv - queued configuration held while the channel is busy
module udma_addrgen_cfg_shadow
  import udma_addrgen_pkg::*;
(
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         consume_i,
  input  addrgen_cfg_t cfg_i,
  output addrgen_cfg_t cfg_o,
  output logic         pending_o
);

  addrgen_cfg_t cfg_q;
  logic         pending_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_q     <= '0;
      pending_q <= 1'b0;
    end else if (clr_i) begin
      cfg_q     <= '0;
      pending_q <= 1'b0;
    end else if (load_i) begin
      cfg_q     <= cfg_i;
      pending_q <= 1'b1;
    end else if (consume_i) begin
      pending_q <= 1'b0;
    end
  end

  assign cfg_o     = cfg_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/udma_ch_addrgen_2d.sv
// rtl/udma_ch_addrgen_2d.sv - per-channel L2 address generator with 2D stride and queued reload
module udma_ch_addrgen_2d
  import udma_addrgen_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = ADDR_W,
  parameter int unsigned TRANS_SIZE     = TRANS_W,
  parameter int unsigned STRIDE_SIZE    = STRIDE_W
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [STRIDE_SIZE-1:0]    cfg_row_len_i,
  input  logic [STRIDE_SIZE-1:0]    cfg_stride_i,
  input  logic                      cfg_mode_2d_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  input  logic                      int_not_stall_i,
  input  logic                      int_ch_grant_i,
  input  logic [1:0]                int_datasize_i,
  output logic [L2_AWIDTH_NOAL-1:0] int_ch_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     int_ch_bytes_left_o,
  output logic                      int_ch_en_o,
  output logic                      int_ch_pending_o,
  output logic                      int_ch_sot_o,
  output logic                      int_ch_events_o,
  output logic                      int_ch_row_evt_o
);

  localparam int unsigned AW = L2_AWIDTH_NOAL;
  localparam int unsigned TW = TRANS_SIZE;
  localparam int unsigned SW = STRIDE_SIZE;

  logic          en_q, en_d, sot_q, sot_d, evt_q, evt_d, row_evt_q, row_evt_d;
  logic [AW-1:0] addr_q, addr_d, row_base_q, row_base_d, next_row_base;
  logic [TW-1:0] left_q, left_d;
  logic [SW-1:0] row_left_q, row_left_d;
  addrgen_cfg_t  act_q, act_d, cfg_in, shadow_cfg, load_cfg;
  logic          pending, beat, last, row_end, do_load, shadow_load;
  logic [2:0]    inc;

  assign cfg_in = '{start: cfg_startaddr_i, size: cfg_size_i, row_len: cfg_row_len_i,
                    stride: cfg_stride_i, mode_2d: cfg_mode_2d_i};

  assign inc           = datasize_to_inc(datasize_e'(int_datasize_i));
  assign beat          = en_q & int_ch_grant_i & int_not_stall_i & (inc != 3'd0);
  assign last          = left_q <= TW'(inc);
  assign row_end       = act_q.mode_2d & (row_left_q <= SW'(inc));
  assign next_row_base = row_base_q + AW'(act_q.stride);

  // A same-cycle enable overrides whatever is already queued.
  assign load_cfg    = cfg_en_i ? cfg_in : (pending ? shadow_cfg : act_q);
  assign shadow_load = cfg_en_i & en_q & ~(beat & last);

  udma_addrgen_cfg_shadow u_shadow (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (cfg_clr_i),
    .load_i    (shadow_load),
    .consume_i (beat & last),
    .cfg_i     (cfg_in),
    .cfg_o     (shadow_cfg),
    .pending_o (pending)
  );

  always_comb begin
    en_d       = en_q;
    sot_d      = sot_q;
    addr_d     = addr_q;
    left_d     = left_q;
    row_base_d = row_base_q;
    row_left_d = row_left_q;
    act_d      = act_q;
    evt_d      = 1'b0;
    row_evt_d  = 1'b0;
    do_load    = 1'b0;

    if (cfg_clr_i) begin
      en_d       = 1'b0;
      sot_d      = 1'b0;
      addr_d     = '0;
      left_d     = '0;
      row_base_d = '0;
      row_left_d = '0;
      act_d      = '0;
    end else if (cfg_en_i && !en_q) begin
      do_load = 1'b1;
    end else if (beat) begin
      if (!last) begin
        left_d = left_q - TW'(inc);
        sot_d  = 1'b0;
        if (row_end) begin
          row_base_d = next_row_base;
          addr_d     = next_row_base;
          row_left_d = act_q.row_len;
          row_evt_d  = 1'b1;
        end else begin
          addr_d     = addr_q + AW'(inc);
          row_left_d = row_left_q - SW'(inc);
        end
      end else begin
        evt_d     = 1'b1;
        row_evt_d = act_q.mode_2d;
        if (cfg_en_i || pending || cfg_continuous_i) begin
          do_load = 1'b1;
        end else begin
          en_d       = 1'b0;
          sot_d      = 1'b0;
          addr_d     = '0;
          left_d     = '0;
          row_base_d = '0;
          row_left_d = '0;
        end
      end
    end

    if (do_load) begin
      act_d      = load_cfg;
      en_d       = 1'b1;
      sot_d      = 1'b1;
      addr_d     = load_cfg.start;
      row_base_d = load_cfg.start;
      left_d     = load_cfg.size;
      row_left_d = load_cfg.row_len;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q       <= 1'b0;
      sot_q      <= 1'b0;
      evt_q      <= 1'b0;
      row_evt_q  <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      row_base_q <= '0;
      row_left_q <= '0;
      act_q      <= '0;
    end else begin
      en_q       <= en_d;
      sot_q      <= sot_d;
      evt_q      <= evt_d;
      row_evt_q  <= row_evt_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      row_base_q <= row_base_d;
      row_left_q <= row_left_d;
      act_q      <= act_d;
    end
  end

  assign int_ch_curr_addr_o  = addr_q;
  assign int_ch_bytes_left_o = left_q;
  assign int_ch_en_o         = en_q;
  assign int_ch_pending_o    = pending;
  assign int_ch_sot_o        = sot_q;
  assign int_ch_events_o     = evt_q;
  assign int_ch_row_evt_o    = row_evt_q;

endmodule

// File: tb/tb_udma_ch_addrgen_2d.sv
// tb/tb_udma_ch_addrgen_2d.sv - self-checking bench for udma_ch_addrgen_2d
module tb_udma_ch_addrgen_2d;

  localparam int AW    = 19;
  localparam int TW    = 20;
  localparam int SW    = 19;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [AW-1:0] cfg_startaddr_i = '0;
  logic [TW-1:0] cfg_size_i = '0;
  logic [SW-1:0] cfg_row_len_i = '0;
  logic [SW-1:0] cfg_stride_i = '0;
  logic          cfg_mode_2d_i = 1'b0;
  logic          cfg_continuous_i = 1'b0;
  logic          cfg_en_i = 1'b0;
  logic          cfg_clr_i = 1'b0;
  logic          int_not_stall_i = 1'b0;
  logic          int_ch_grant_i = 1'b0;
  logic [1:0]    int_datasize_i = 2'b00;
  logic [AW-1:0] int_ch_curr_addr_o;
  logic [TW-1:0] int_ch_bytes_left_o;
  logic          int_ch_en_o, int_ch_pending_o, int_ch_sot_o, int_ch_events_o, int_ch_row_evt_o;

  udma_ch_addrgen_2d #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW), .STRIDE_SIZE(SW)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .cfg_startaddr_i     (cfg_startaddr_i),
    .cfg_size_i          (cfg_size_i),
    .cfg_row_len_i       (cfg_row_len_i),
    .cfg_stride_i        (cfg_stride_i),
    .cfg_mode_2d_i       (cfg_mode_2d_i),
    .cfg_continuous_i    (cfg_continuous_i),
    .cfg_en_i            (cfg_en_i),
    .cfg_clr_i           (cfg_clr_i),
    .int_not_stall_i     (int_not_stall_i),
    .int_ch_grant_i      (int_ch_grant_i),
    .int_datasize_i      (int_datasize_i),
    .int_ch_curr_addr_o  (int_ch_curr_addr_o),
    .int_ch_bytes_left_o (int_ch_bytes_left_o),
    .int_ch_en_o         (int_ch_en_o),
    .int_ch_pending_o    (int_ch_pending_o),
    .int_ch_sot_o        (int_ch_sot_o),
    .int_ch_events_o     (int_ch_events_o),
    .int_ch_row_evt_o    (int_ch_row_evt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in buffer is tracked as (row start, offset into row).
  bit m_en, m_sot, m_evt, m_rowevt, m_pend;
  int m_left, m_row_start, m_row_off;
  int a_start, a_size, a_rowlen, a_stride;
  bit a_2d;
  int s_start, s_size, s_rowlen, s_stride;
  bit s_2d;

  function automatic int m_addr();
    return (m_row_start + m_row_off) & AMASK;
  endfunction

  task automatic m_start(input int st, input int sz, input int rl, input int sd, input bit m2);
    a_start = st; a_size = sz; a_rowlen = rl; a_stride = sd; a_2d = m2;
    m_en = 1; m_sot = 1; m_left = sz; m_row_start = st; m_row_off = 0;
  endtask

  task automatic m_idle();
    m_en = 0; m_sot = 0; m_left = 0; m_row_start = 0; m_row_off = 0;
  endtask

  task automatic model_reset();
    m_idle();
    m_evt = 0; m_rowevt = 0; m_pend = 0;
    a_start = 0; a_size = 0; a_rowlen = 0; a_stride = 0; a_2d = 0;
  endtask

  task automatic model_step();
    bit was_en, b, lastb;
    int inc;
    if (!rstn_i || cfg_clr_i) begin
      model_reset();
      return;
    end
    m_evt = 0; m_rowevt = 0;
    was_en = m_en;
    inc = (int_datasize_i == 2'd0) ? 1 : (int_datasize_i == 2'd1) ? 2 : (int_datasize_i == 2'd2) ? 4 : 0;
    b = m_en && int_ch_grant_i && int_not_stall_i && (inc != 0);
    lastb = b && (m_left <= inc);
    if (!was_en && cfg_en_i) begin
      m_start(int'(cfg_startaddr_i), int'(cfg_size_i), int'(cfg_row_len_i), int'(cfg_stride_i), cfg_mode_2d_i);
    end else if (b && !lastb) begin
      m_left -= inc;
      m_sot = 0;
      if (a_2d && (a_rowlen - m_row_off) <= inc) begin
        m_row_start = (m_row_start + a_stride) & AMASK;
        m_row_off = 0;
        m_rowevt = 1;
      end else begin
        m_row_off += inc;
      end
    end else if (lastb) begin
      m_evt = 1;
      m_rowevt = a_2d;
      if (cfg_en_i) begin
        m_pend = 0;
        m_start(int'(cfg_startaddr_i), int'(cfg_size_i), int'(cfg_row_len_i), int'(cfg_stride_i), cfg_mode_2d_i);
      end else if (m_pend) begin
        m_pend = 0;
        m_start(s_start, s_size, s_rowlen, s_stride, s_2d);
      end else if (cfg_continuous_i) begin
        m_start(a_start, a_size, a_rowlen, a_stride, a_2d);
      end else begin
        m_idle();
      end
    end
    if (was_en && cfg_en_i && !lastb) begin
      s_start = int'(cfg_startaddr_i); s_size = int'(cfg_size_i);
      s_rowlen = int'(cfg_row_len_i); s_stride = int'(cfg_stride_i); s_2d = cfg_mode_2d_i;
      m_pend = 1;
    end
  endtask

  task automatic compare_all();
    check("en",        32'(int_ch_en_o),         32'(m_en));
    check("sot",       32'(int_ch_sot_o),        32'(m_sot));
    check("addr",      32'(int_ch_curr_addr_o),  m_addr());
    check("bytes_left",32'(int_ch_bytes_left_o), m_left);
    check("pending",   32'(int_ch_pending_o),    32'(m_pend));
    check("events",    32'(int_ch_events_o),     32'(m_evt));
    check("row_evt",   32'(int_ch_row_evt_o),    32'(m_rowevt));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input logic [AW-1:0] st, input logic [TW-1:0] sz,
                         input logic [SW-1:0] rl, input logic [SW-1:0] sd, input logic m2);
    cfg_startaddr_i = st; cfg_size_i = sz; cfg_row_len_i = rl; cfg_stride_i = sd; cfg_mode_2d_i = m2;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    compare_all();
    rstn_i = 1'b1;
    cycle();

    // 1D single buffer
    int_ch_grant_i = 1; int_not_stall_i = 1; int_datasize_i = 2'd2; cfg_continuous_i = 0;
    set_cfg(19'h100, 20'd8, 19'd0, 19'd0, 1'b0);
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("d1_addr0", 32'(int_ch_curr_addr_o), 32'h100);
    check("d1_sot", 32'(int_ch_sot_o), 32'd1);
    cycle();
    check("d1_addr1", 32'(int_ch_curr_addr_o), 32'h104);
    cycle();
    check("d1_events", 32'(int_ch_events_o), 32'd1);
    check("d1_en_off", 32'(int_ch_en_o), 32'd0);
    check("d1_addr_off", 32'(int_ch_curr_addr_o), 32'd0);
    cycle();

    // 2D buffer with a reload queued mid-buffer
    set_cfg(19'h1000, 20'd16, 19'd8, 19'h40, 1'b1);
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("d2_addr0", 32'(int_ch_curr_addr_o), 32'h1000);
    cycle();
    check("d2_addr1", 32'(int_ch_curr_addr_o), 32'h1004);
    set_cfg(19'h2000, 20'd4, 19'd0, 19'd0, 1'b0);
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("d2_addr2", 32'(int_ch_curr_addr_o), 32'h1040);
    check("d2_row_evt2", 32'(int_ch_row_evt_o), 32'd1);
    check("q_pending_set", 32'(int_ch_pending_o), 32'd1);
    cycle();
    check("d2_addr3", 32'(int_ch_curr_addr_o), 32'h1044);
    cycle();
    check("d2_events", 32'(int_ch_events_o), 32'd1);
    check("d2_row_evt4", 32'(int_ch_row_evt_o), 32'd1);
    check("q_addr", 32'(int_ch_curr_addr_o), 32'h2000);
    check("q_sot", 32'(int_ch_sot_o), 32'd1);
    check("q_pending_clr", 32'(int_ch_pending_o), 32'd0);
    cycle();
    check("q_en_off", 32'(int_ch_en_o), 32'd0);

    // Continuous byte buffer
    set_cfg(19'h200, 20'd2, 19'd0, 19'd0, 1'b0);
    cfg_continuous_i = 1; int_datasize_i = 2'd0;
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("c_addr0", 32'(int_ch_curr_addr_o), 32'h200);
    cycle();
    check("c_addr1", 32'(int_ch_curr_addr_o), 32'h201);
    cycle();
    check("c_addr2", 32'(int_ch_curr_addr_o), 32'h200);
    check("c_events", 32'(int_ch_events_o), 32'd1);
    cycle();
    check("c_addr3", 32'(int_ch_curr_addr_o), 32'h201);

    // Stall, then reserved datasize
    int_not_stall_i = 0;
    repeat (3) cycle();
    check("s_addr", 32'(int_ch_curr_addr_o), 32'h201);
    check("s_left", 32'(int_ch_bytes_left_o), 32'd1);
    int_not_stall_i = 1; int_datasize_i = 2'd3;
    repeat (2) cycle();
    check("r_addr", 32'(int_ch_curr_addr_o), 32'h201);
    check("r_events", 32'(int_ch_events_o), 32'd0);
    int_datasize_i = 2'd0;

    // Clear while a reload is pending
    int_ch_grant_i = 0;
    set_cfg(19'h400, 20'd6, 19'd0, 19'd0, 1'b0);
    cfg_en_i = 1; cycle();
    check("x_pending", 32'(int_ch_pending_o), 32'd1);
    cfg_clr_i = 1; cycle(); cfg_clr_i = 0; cfg_en_i = 0;
    check("x_en", 32'(int_ch_en_o), 32'd0);
    check("x_pending_clr", 32'(int_ch_pending_o), 32'd0);
    check("x_addr", 32'(int_ch_curr_addr_o), 32'd0);
    cfg_continuous_i = 0;
    set_cfg(19'h300, 20'd4, 19'd0, 19'd0, 1'b0);
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("x_restart_addr", 32'(int_ch_curr_addr_o), 32'h300);
    check("x_restart_sot", 32'(int_ch_sot_o), 32'd1);
    int_ch_grant_i = 1;
    repeat (6) cycle();

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      int_ch_grant_i  = ($urandom % 4) != 0;
      int_not_stall_i = ($urandom % 8) != 0;
      int_datasize_i  = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
      cfg_clr_i       = ($urandom % 200) == 0;
      cfg_en_i        = ($urandom % 10) == 0;
      if (($urandom % 16) == 0) cfg_continuous_i = ~cfg_continuous_i;
      if (($urandom % 3) == 0) begin
        set_cfg((($urandom % 4) == 0) ? 19'(AMASK - ($urandom % 16)) : 19'($urandom),
                (($urandom % 5) == 0) ? 20'($urandom % 4) : 20'($urandom % 41),
                19'($urandom % 13),
                (($urandom % 2) == 0) ? 19'($urandom % 64) : 19'($urandom),
                1'($urandom % 2));
      end
      cycle();
    end
    cfg_clr_i = 0; cfg_en_i = 0;

    // Asynchronous reset mid-transfer
    int_ch_grant_i = 0; cfg_continuous_i = 0;
    set_cfg(19'h500, 20'd12, 19'd4, 19'h20, 1'b1);
    cfg_en_i = 1; cycle(); cfg_en_i = 0;
    check("ar_en_before", 32'(int_ch_en_o), 32'd1);
    #2 rstn_i = 0;
    model_reset();
    #1;
    compare_all();
    check("ar_en_after", 32'(int_ch_en_o), 32'd0);
    cycle();
    rstn_i = 1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
